// File: rtl/fifo_pkg.sv
// Shared constants and pointer helpers for the parametrised show-ahead FIFO.
// Optional high-water mark output is enabled by PARAM_FIFO_HWM_EN.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF     = 12;
  localparam int FIFO_DEPTH_DEF     = 4096;
  localparam int FIFO_AF_MARGIN_DEF = 4;

  // Pointers carry one extra wrap bit above the aw address bits.
  function automatic logic ptr_empty(
    input logic [31:0] w,
    input logic [31:0] r,
    input int unsigned aw
  );
    logic [31:0] m;
    m = (32'd1 << (aw + 1)) - 32'd1;
    return ((w ^ r) & m) == 32'd0;
  endfunction

  function automatic logic ptr_full(
    input logic [31:0] w,
    input logic [31:0] r,
    input int unsigned aw
  );
    logic [31:0] m;
    m = (32'd1 << (aw + 1)) - 32'd1;
    return ((w ^ r) & m) == (32'd1 << aw);
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Push/pop/status bundle between the FIFO and its producer/consumer.
// The hwm signal exists only when PARAM_FIFO_HWM_EN is defined.
interface param_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              data_write;
  logic [WIDTH-1:0]  data_in;
  logic              full;
  logic              almost_full;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid;
  logic              data_adv;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
`ifdef PARAM_FIFO_HWM_EN
  logic [ADDR_W:0]   hwm;
`endif

  modport master (
    output flush, data_write, data_in, data_adv,
    input  full, almost_full, data_out, data_valid,
    input  count, overflow, underflow
`ifdef PARAM_FIFO_HWM_EN
    , input hwm
`endif
  );

  modport slave (
    input  flush, data_write, data_in, data_adv,
    output full, almost_full, data_out, data_valid,
    output count, overflow, underflow
`ifdef PARAM_FIFO_HWM_EN
    , output hwm
`endif
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// No reset; contents are only meaningful between the FIFO pointers.
module fifo_ram #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised show-ahead single-clock FIFO with status and sticky errors.
// Define PARAM_FIFO_HWM_EN to add the high-water mark output.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - FIFO_AF_MARGIN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t FULL_C = ptr_t'(DEPTH);
  localparam ptr_t AF_C   = ptr_t'(AF_LEVEL);

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  ptr_t             count;
  ptr_t             rd_next;
  ptr_t             count_next;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] ram_q;
  logic             dvalid;
  logic             ovf;
  logic             udf;
  logic             full_c;
  logic             wr_acc;
  logic             rd_acc;
  logic             head_ok;

  assign full_c = (count == FULL_C);

  // Flush suppresses both accepts so nothing lands in RAM that cycle.
  assign wr_acc = bus.data_write & ~full_c & ~bus.flush;
  assign rd_acc = bus.data_adv & dvalid & ~bus.flush;

  assign rd_next    = rd_ptr + ptr_t'(rd_acc);
  assign count_next = count + ptr_t'(wr_acc) - ptr_t'(rd_acc);
  assign head_ok    = ~ptr_empty(32'(wr_ptr), 32'(rd_next),
                                 ADDR_W);

  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_next[ADDR_W-1:0]),
    .rdata (ram_q)
  );

`ifdef PARAM_FIFO_HWM_EN
  ptr_t hwm_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
`ifdef PARAM_FIFO_HWM_EN
      hwm_q  <= '0;
`endif
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
`ifdef PARAM_FIFO_HWM_EN
      hwm_q  <= '0;
`endif
    end else begin
      wr_ptr <= wr_ptr + ptr_t'(wr_acc);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (bus.data_write & full_c) ovf <= 1'b1;
      if (bus.data_adv & ~dvalid)  udf <= 1'b1;
      // Head compares against the pre-edge write pointer: new words
      // become visible one edge after they are written.
      if (head_ok) begin
        dout   <= ram_q;
        dvalid <= 1'b1;
      end else begin
        dout   <= '0;
        dvalid <= 1'b0;
      end
`ifdef PARAM_FIFO_HWM_EN
      if (count_next > hwm_q) hwm_q <= count_next;
`endif
    end
  end

  assign bus.full        = full_c;
  assign bus.almost_full = (count >= AF_C);
  assign bus.data_out    = dout;
  assign bus.data_valid  = dvalid;
  assign bus.count       = count;
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;
`ifdef PARAM_FIFO_HWM_EN
  assign bus.hwm         = hwm_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo with a queue-based reference model.
// Covers hwm when PARAM_FIFO_HWM_EN is defined.
module tb_param_fifo;

  localparam int W  = 12;
  localparam int D  = 8;
  localparam int AF = 6;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  param_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_fifo #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue plus the visible head word.
  logic [W-1:0] q[$];
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_ovf;
  logic         m_udf;
  int           m_hwm;

  task automatic m_clear();
    q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_hwm   = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    bit wacc;
    bit racc;
    if (!rst) begin
      m_clear();
    end else if (bus.flush) begin
      m_clear();
    end else begin
      wacc = bus.data_write && (q.size() < D);
      racc = bus.data_adv && m_valid;
      if (bus.data_write && q.size() == D) m_ovf = 1'b1;
      if (bus.data_adv && !m_valid) m_udf = 1'b1;
      if (racc) void'(q.pop_front());
      if (q.size() > 0) begin
        m_out   = q[0];
        m_valid = 1'b1;
      end else begin
        m_out   = '0;
        m_valid = 1'b0;
      end
      if (wacc) q.push_back(bus.data_in);
      if (q.size() > m_hwm) m_hwm = q.size();
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_dout",  32'(bus.data_out),    32'(m_out));
    chk("m_valid", 32'(bus.data_valid),  32'(m_valid));
    chk("m_count", 32'(bus.count),       q.size());
    chk("m_full",  32'(bus.full),        32'(q.size() == D));
    chk("m_af",    32'(bus.almost_full), 32'(q.size() >= AF));
    chk("m_ovf",   32'(bus.overflow),    32'(m_ovf));
    chk("m_udf",   32'(bus.underflow),   32'(m_udf));
`ifdef PARAM_FIFO_HWM_EN
    chk("m_hwm",   32'(bus.hwm),         m_hwm);
`endif
  end

  task automatic cyc(input logic fl, input logic wr,
                     input logic [W-1:0] din, input logic adv);
    bus.flush      = fl;
    bus.data_write = wr;
    bus.data_in    = din;
    bus.data_adv   = adv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.data_write = 1'b0;
    bus.data_in    = '0;
    bus.data_adv   = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_dout",  32'(bus.data_out),    32'h0);
    chk("rst_valid", 32'(bus.data_valid),  32'h0);
    chk("rst_count", 32'(bus.count),       32'h0);
    chk("rst_full",  32'(bus.full),        32'h0);
    chk("rst_af",    32'(bus.almost_full), 32'h0);

    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 12'(i), 0);
      if (i == 1) chk("lat_valid0", 32'(bus.data_valid), 32'h0);
      if (i == 2) begin
        chk("lat_valid1", 32'(bus.data_valid), 32'h1);
        chk("lat_dout1",  32'(bus.data_out),   32'h001);
      end
      if (i == 5) chk("af_at5", 32'(bus.almost_full), 32'h0);
      if (i == 6) chk("af_at6", 32'(bus.almost_full), 32'h1);
      if (i == 7) chk("full_at7", 32'(bus.full), 32'h0);
      if (i == 8) chk("full_at8", 32'(bus.full), 32'h1);
    end
    cyc(0, 1, 12'h009, 0);
    chk("ovf_set",   32'(bus.overflow), 32'h1);
    chk("ovf_count", 32'(bus.count),    32'h8);

    for (int j = 1; j <= 8; j++) begin
      cyc(0, 0, '0, 1);
      chk("pop_dout", 32'(bus.data_out), (j < 8) ? 32'(j + 1) : 32'h0);
      chk("pop_valid", 32'(bus.data_valid), (j < 8) ? 32'h1 : 32'h0);
    end
    cyc(0, 0, '0, 1);
    chk("udf_set", 32'(bus.underflow), 32'h1);

    cyc(0, 1, 12'h100, 0);
    cyc(0, 1, 12'h101, 0);
    cyc(0, 1, 12'h102, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 12'(12'h103 + i), 1);
      chk("pp_count", 32'(bus.count),    32'h3);
      chk("pp_dout",  32'(bus.data_out), 32'(12'h101 + i));
    end
`ifdef PARAM_FIFO_HWM_EN
    chk("hwm_8", 32'(bus.hwm), 32'h8);
`endif

    cyc(0, 1, 12'h300, 0);
    cyc(0, 1, 12'h301, 0);
    chk("pre_fl_count", 32'(bus.count), 32'h5);
    cyc(1, 1, 12'h7FF, 1);
    chk("fl_count", 32'(bus.count),      32'h0);
    chk("fl_valid", 32'(bus.data_valid), 32'h0);
    chk("fl_ovf",   32'(bus.overflow),   32'h0);
    chk("fl_udf",   32'(bus.underflow),  32'h0);
`ifdef PARAM_FIFO_HWM_EN
    chk("fl_hwm",   32'(bus.hwm),        32'h0);
`endif
    cyc(0, 0, '0, 0);
    chk("fl_nostore", 32'(bus.data_valid), 32'h0);

    cyc(0, 1, 12'h200, 0);
    cyc(0, 1, 12'h201, 0);
    cyc(0, 1, 12'h202, 0);
    bus.data_in = 12'h203;
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.data_write = 1'b0;
    #1;
    chk("arst_dout",  32'(bus.data_out),   32'h0);
    chk("arst_valid", 32'(bus.data_valid), 32'h0);
    chk("arst_count", 32'(bus.count),      32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 12'hABC, 0);
    cyc(0, 0, '0, 0);
    chk("post_dout",  32'(bus.data_out),   32'hABC);
    chk("post_valid", 32'(bus.data_valid), 32'h1);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised, show-ahead, single-clock FIFO that succeeds the fixed 12-bit × 4096 FIFO in the CPU I/O path.
- Adds configurable width and depth, full/almost-full/count status, a valid flag, sticky overflow/underflow errors and a synchronous flush.
- Sits between the host-side input writer and the CPU IN port, and between the CPU OUT port and the host reader.
- Keeps the existing contract that data_out reads zero when the FIFO is empty.

Parameters:
- WIDTH, 12, data word width in bits.
- DEPTH, 4096, number of entries; must be a power of two and ≥ 2.
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL.
- ADDR_W (localparam), $clog2(DEPTH), RAM address width; pointers are ADDR_W+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous clear of contents and error flags.
- data_write  in  1  push request.
- data_in  in  WIDTH  push data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- data_out  out  WIDTH  head entry (registered); zero when data_valid=0.
- data_valid  out  1  data_out holds a real entry.
- data_adv  in  1  pop request; consumes data_out when data_valid=1.
- count  out  ADDR_W+1  occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: data_adv was asserted while data_valid=0.

Behaviour:
- Reset (rst=0, asynchronous) clears: wr_ptr, rd_ptr, count, data_out, data_valid, overflow, underflow, hwm. All become 0. RAM contents are not reset.
- Write accept (wr_acc): data_write & ~full. On accept, RAM[wr_ptr[ADDR_W-1:0]] ← data_in and wr_ptr increments.
- Write while full: data is dropped, pointers are unchanged, overflow ← 1. This holds even if data_adv pops in the same cycle; there is no pass-through when full.
- Pop accept (rd_acc): data_adv & data_valid. On accept, rd_ptr increments.
- Pop while empty: ignored; underflow ← 1.
- Show-ahead output register, evaluated every edge:
  - rd_next = rd_ptr + rd_acc.
  - If wr_ptr (value before this edge) ≠ rd_next: data_out ← RAM[rd_next], data_valid ← 1.
  - Otherwise: data_out ← 0, data_valid ← 0.
- Latency: a word written at edge k into an empty FIFO appears on data_out/data_valid after edge k+1. Back-to-back pops run at one word per cycle with no bubble.
- count ← count + wr_acc − rd_acc. A simultaneous accepted push and pop leaves count unchanged.
- full and almost_full are combinational from count.
- Wrap-around: pointers wrap modulo 2·DEPTH. Full when MSBs differ and low bits are equal; empty when pointers are equal.
- flush=1: next edge clears pointers, count, data_out, data_valid, overflow, underflow and hwm. It overrides a same-cycle write and pop: no accept, and no error flag is set.
- Reset asserted mid-transfer aborts immediately. The first write after deassertion lands at RAM[0].

Optional Feature:
- Macro: PARAM_FIFO_HWM_EN.
- Defined: adds output port hwm (ADDR_W+1 bits), a high-water mark. hwm ← max(hwm, count_next) every edge, where count_next is the count value being loaded at that edge. Cleared by rst and flush.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - default constants FIFO_WIDTH_DEF=12, FIFO_DEPTH_DEF=4096, FIFO_AF_MARGIN_DEF=4;
  - a pointer-arithmetic helper function for full/empty.
- One sub-module, fifo_ram: a simple dual-port RAM with write port (we, waddr, wdata) and asynchronous read (raddr, rdata) driven by rd_next. It has no reset.
- Pointer, count, flag and output-register logic stay in param_fifo.

Test Plan:
- Reset then idle (WIDTH=12, DEPTH=8, AF_LEVEL=6) → data_out=0, data_valid=0, count=0, full=0, almost_full=0.
- Push 0x001..0x008 on consecutive cycles with no pops:
  - data_valid rises one edge after the first push with data_out=0x001;
  - almost_full=1 at count=6; full=1 at count=8;
  - a 9th push with 0x009 sets overflow=1 and leaves count at 8.
- Pop continuously from full → data_out steps 0x001..0x008 one per cycle with no bubble. After the last pop, data_valid=0 and data_out=0. One further pop sets underflow=1.
- Simultaneous push/pop at count=3 for 20 cycles, crossing the pointer wrap:
  - count stays 3;
  - output order equals input order;
  - with PARAM_FIFO_HWM_EN defined, hwm=8 from the earlier fill.
- Fill 5 entries, assert flush with data_write=1 → next cycle count=0, data_valid=0, overflow=0, underflow=0, and the flush-cycle word is not stored.
- Drive rst low asynchronously mid-burst (between clock edges) → outputs zero immediately. After release, push 0xABC → data_out=0xABC one edge later.
